// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-attached accumulator core: opcodes,
// register/source codes, instruction field positions and FSM states.
package cpu_pkg;

  // Opcodes in ir[7:5]
  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_JC  = 3'b111;

  // Register codes; as a source, code 11 selects the immediate word instead of Q
  localparam logic [1:0] REG_A   = 2'b00;
  localparam logic [1:0] REG_B   = 2'b01;
  localparam logic [1:0] REG_X   = 2'b10;
  localparam logic [1:0] REG_Q   = 2'b11;
  localparam logic [1:0] SRC_IMM = 2'b11;

  // Instruction byte layout: op[7:5] dst[4:3] src[2:1] h[0]
  localparam int IR_OP_HI  = 7;
  localparam int IR_OP_LO  = 5;
  localparam int IR_DST_HI = 4;
  localparam int IR_DST_LO = 3;
  localparam int IR_SRC_HI = 2;
  localparam int IR_SRC_LO = 1;
  localparam int IR_HALT   = 0;

  typedef enum logic [2:0] {FETCH, IMM, EXEC, MEM, HALT} cpuState_t;

  // ADD, SUB and LD work on fixed operands and never consume an immediate
  function automatic logic usesSrc(input logic [2:0] op);
    return op inside {OP_MOV, OP_ST, OP_JMP, OP_JZ, OP_JC};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational adder/subtractor. For subtraction carry is the
// no-borrow flag, i.e. carry = (a >= b).
module cpu_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W-1:0] bOperand;
  logic [DATA_W:0]   sum;

  // a - b is computed as a + ~b + 1 so the carry-out is the no-borrow flag
  always_comb begin
    bOperand = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, bOperand} + {{DATA_W{1'b0}}, sub};
    result   = sum[DATA_W-1:0];
    carry    = sum[DATA_W];
  end

endmodule

// File: rtl/cpu_core_bus.sv
// Multi-cycle accumulator/register core on a single req/ack memory bus.
// FETCH -> [IMM] -> EXEC -> [MEM] -> FETCH, with an absorbing HALT state.
module cpu_core_bus
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] qout,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_STEP = 1;

  cpuState_t         stateReg, stateNext;
  logic [DATA_W-1:0] regFile [4];
  logic              carryReg, carryNext;
  logic [ADDR_W-1:0] pcReg, pcNext;
  logic [7:0]        irReg, irNext;
  logic [DATA_W-1:0] immReg, immNext;

  logic              regWe;
  logic [DATA_W-1:0] regWdata;
  logic [2:0]        opField;
  logic [1:0]        dstSel, srcSel;
  logic              haltBit;
  logic [DATA_W-1:0] srcVal;
  logic [ADDR_W-1:0] srcAddr, xAddr;
  logic              fetchNeedsImm;
  logic [DATA_W-1:0] aluResult;
  logic              aluCarry;

  assign opField = irReg[IR_OP_HI:IR_OP_LO];
  assign dstSel  = irReg[IR_DST_HI:IR_DST_LO];
  assign srcSel  = irReg[IR_SRC_HI:IR_SRC_LO];
  assign haltBit = irReg[IR_HALT];
  assign srcVal  = (srcSel == SRC_IMM) ? immReg : regFile[srcSel];

  // Decoded straight off the bus so the FSM can branch to IMM on the fetch ack
  assign fetchNeedsImm = !mem_rdata[IR_HALT] && usesSrc(mem_rdata[IR_OP_HI:IR_OP_LO])
                         && (mem_rdata[IR_SRC_HI:IR_SRC_LO] == SRC_IMM);

  // Data values become addresses by truncation or zero-extension
  if (DATA_W >= ADDR_W) begin : gAddrTrunc
    assign srcAddr = srcVal[ADDR_W-1:0];
    assign xAddr   = regFile[REG_X][ADDR_W-1:0];
  end else begin : gAddrExt
    assign srcAddr = {{(ADDR_W-DATA_W){1'b0}}, srcVal};
    assign xAddr   = {{(ADDR_W-DATA_W){1'b0}}, regFile[REG_X]};
  end

  cpu_alu #(.DATA_W(DATA_W)) uAlu (
    .a      (regFile[REG_A]),
    .b      (regFile[REG_B]),
    .sub    (opField == OP_SUB),
    .result (aluResult),
    .carry  (aluCarry)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= FETCH;
    else       stateReg <= stateNext;
  end

  // Next-state logic: bus states wait for ack, EXEC always lasts one cycle
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FETCH:   if (mem_ack) stateNext = fetchNeedsImm ? IMM : EXEC;
      IMM:     if (mem_ack) stateNext = EXEC;
      EXEC: begin
        if (haltBit)                                   stateNext = HALT;
        else if (opField == OP_LD || opField == OP_ST) stateNext = MEM;
        else                                           stateNext = FETCH;
      end
      MEM:     if (mem_ack) stateNext = FETCH;
      HALT:    stateNext = HALT;
      default: stateNext = FETCH;
    endcase
  end

  // Bus outputs; reset kills a request immediately, ahead of the flops
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pcReg;
    mem_wdata = '0;
    case (stateReg)
      FETCH, IMM: mem_req = 1'b1;
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = (opField == OP_ST);
        mem_addr  = xAddr;
        mem_wdata = srcVal;
      end
      default: ;
    endcase
    if (reset) mem_req = 1'b0;
  end

  // Datapath next values for the instruction, PC, immediate, flag and register file
  always_comb begin
    regWe     = 1'b0;
    regWdata  = aluResult;
    carryNext = carryReg;
    pcNext    = pcReg;
    irNext    = irReg;
    immNext   = immReg;
    case (stateReg)
      FETCH: if (mem_ack) begin
        irNext = mem_rdata[7:0];
        pcNext = pcReg + PC_STEP;
      end
      IMM: if (mem_ack) begin
        immNext = mem_rdata;
        pcNext  = pcReg + PC_STEP;
      end
      EXEC: if (!haltBit) begin
        case (opField)
          OP_MOV: begin
            regWe    = 1'b1;
            regWdata = srcVal;
          end
          OP_ADD, OP_SUB: begin
            regWe     = 1'b1;
            carryNext = aluCarry;
          end
          OP_JMP: pcNext = srcAddr;
          OP_JZ:  if (regFile[REG_A] == '0) pcNext = srcAddr;
          OP_JC:  if (carryReg) pcNext = srcAddr;
          default: ;
        endcase
      end
      MEM: if (mem_ack && opField == OP_LD) begin
        regWe    = 1'b1;
        regWdata = mem_rdata;
      end
      default: ;
    endcase
  end

  // Control registers: PC, instruction, immediate and carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg    <= RESET_PC;
      irReg    <= '0;
      immReg   <= '0;
      carryReg <= 1'b0;
    end else begin
      pcReg    <= pcNext;
      irReg    <= irNext;
      immReg   <= immNext;
      carryReg <= carryNext;
    end
  end

  // Register file A/B/X/Q, one writer per entry selected by dst
  for (genvar gi = 0; gi < 4; gi++) begin : gRegs
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                           regFile[gi] <= '0;
      else if (regWe && dstSel == 2'(gi))  regFile[gi] <= regWdata;
    end
  end

  assign qout   = regFile[REG_Q];
  assign halted = (stateReg == HALT);

endmodule

// File: tb/tb_cpu_core_bus.sv
// Bench for cpu_core_bus: a memory responder with programmable wait
// states checks every bus transaction against a queue of expected ones.
module tb_cpu_core_bus;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam logic [AW-1:0] RST_PC = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, mem_ack, halted;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, qout;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } busTxn_t;

  busTxn_t       sbQueue[$];
  logic [DW-1:0] mem [256];
  int            numChecks = 0;
  int            numPass = 0;

  cpu_core_bus #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .qout      (qout),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got === exp) numPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expRead(input logic [AW-1:0] a);
    busTxn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = '0;
    sbQueue.push_back(t);
  endtask

  task automatic expReads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) expRead(AW'(i));
  endtask

  task automatic expWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    busTxn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d;
    sbQueue.push_back(t);
  endtask

  // Unused memory holds HALT so a stray fetch stops the core at a wrong address
  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
  endtask

  task automatic doReset();
    mem_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rstReq", mem_req, 0);
    checkVal("rstQout", qout, 0);
    checkVal("rstHalted", halted, 0);
    reset = 1'b0;
    #1;
  endtask

  // Serve requests with waitCycles idle cycles before each ack. With
  // abortAddr >= 0, reset is asserted in the first cycle of the request
  // at that address, together with its ack.
  task automatic runProgram(input int waitCycles, input logic [DW-1:0] expQ,
                            input int abortAddr, input logic [DW-1:0] abortQ);
    int            waitCnt = 0;
    int            cyc = 0;
    bit            fin = 0;
    bit            aborted = 0;
    logic [AW-1:0] holdAddr = '0;
    logic          holdWe = 1'b0;
    logic [DW-1:0] holdWdata = '0;
    busTxn_t       exp;
    while (!fin && cyc < 2000) begin
      mem_ack = 1'b0;
      if (halted) begin
        fin = 1;
      end else if (mem_req) begin
        if (waitCnt == 0) begin
          holdAddr = mem_addr; holdWe = mem_we; holdWdata = mem_wdata;
        end else begin
          checkVal("addrStable", mem_addr, holdAddr);
          checkVal("weStable", mem_we, holdWe);
          if (holdWe) checkVal("wdataStable", mem_wdata, holdWdata);
        end
        if (abortAddr >= 0 && waitCnt == 0 && mem_addr == abortAddr[AW-1:0]) begin
          checkVal("preAbortQ", qout, abortQ);
          mem_rdata = mem[mem_addr];
          mem_ack = 1'b1;
          reset = 1'b1;
          #1;
          checkVal("abortReqDrop", mem_req, 0);
          $display("bus abort at addr=0x%02h", holdAddr);
          aborted = 1;
          fin = 1;
        end else if (waitCnt >= waitCycles) begin
          if (sbQueue.size() == 0) begin
            checkVal("sbUnderflow", sbQueue.size(), 1);
          end else begin
            exp = sbQueue.pop_front();
            checkVal("busWe", mem_we, exp.we);
            checkVal("busAddr", mem_addr, exp.addr);
            if (exp.we) checkVal("busWdata", mem_wdata, exp.wdata);
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          $display("bus %s addr=0x%02h data=0x%04h", mem_we ? "wr" : "rd", mem_addr,
                   mem_we ? mem_wdata : mem_rdata);
          mem_ack = 1'b1;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end
      if (!fin) begin
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    if (!aborted) begin
      checkVal("haltedReached", halted, 1);
      checkVal("finalQ", qout, expQ);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        checkVal("noReqInHalt", mem_req, 0);
      end
    end
    checkVal("sbEmpty", sbQueue.size(), 0);
  endtask

  // MOV A,#5; MOV B,#3; ADD Q; HALT
  task automatic loadBasic();
    clearMem();
    mem[0] = 16'h0006; mem[1] = 16'h0005; mem[2] = 16'h000E;
    mem[3] = 16'h0003; mem[4] = 16'h0038; mem[5] = 16'h0001;
  endtask

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;

    // Basic program, zero-wait and 3-wait
    for (int w = 0; w <= 3; w += 3) begin
      doReset();
      loadBasic();
      expReads(0, 5);
      runProgram(w, 16'h0008, -1, '0);
    end

    // ADD wraps A to 0 with carry; JC (then JZ) #0x20 taken; at 0x20 MOV Q,B
    for (int v = 0; v < 2; v++) begin
      doReset();
      clearMem();
      mem[0] = 16'h0006; mem[1] = 16'hFFFF; mem[2] = 16'h000E; mem[3] = 16'h0001;
      mem[4] = 16'h0020; mem[5] = (v == 0) ? 16'h00E6 : 16'h00C6; mem[6] = 16'h0020;
      mem[8'h20] = 16'h001A; mem[8'h21] = 16'h0001;
      expReads(0, 6); expRead(8'h20); expRead(8'h21);
      runProgram(1, 16'h0001, -1, '0);
    end

    // A=3, B=5: SUB Q borrows (carry 0), JC #0x30 falls through to HALT at 7
    doReset();
    clearMem();
    mem[0] = 16'h0006; mem[1] = 16'h0003; mem[2] = 16'h000E; mem[3] = 16'h0005;
    mem[4] = 16'h0058; mem[5] = 16'h00E6; mem[6] = 16'h0030; mem[7] = 16'h0001;
    expReads(0, 7);
    runProgram(0, 16'hFFFE, -1, '0);

    // X=0x80, A=0x5A: ST A; LD B; MOV Q,B
    doReset();
    clearMem();
    mem[0] = 16'h0016; mem[1] = 16'h0080; mem[2] = 16'h0006; mem[3] = 16'h005A;
    mem[4] = 16'h0080; mem[5] = 16'h0068; mem[6] = 16'h001A; mem[7] = 16'h0001;
    expReads(0, 4); expWrite(8'h80, 16'h005A); expRead(8'h05); expRead(8'h80); expReads(6, 7);
    runProgram(2, 16'h005A, -1, '0);

    // Reset during the fetch at address 5 with a same-cycle ack
    doReset();
    loadBasic();
    expReads(0, 4);
    runProgram(1, '0, 5, 16'h0008);
    repeat (2) @(negedge clk);
    #1;
    checkVal("midRstReq", mem_req, 0);
    checkVal("midRstQout", qout, 0);
    checkVal("midRstHalted", halted, 0);
    mem_ack = 1'b0;
    reset = 1'b0;
    #1;
    checkVal("postRstReq", mem_req, 1);
    checkVal("postRstAddr", mem_addr, RST_PC);
    expReads(0, 5);
    runProgram(0, 16'h0008, -1, '0);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
